// File: rtl/pipe_pkg.sv
// Shared types and constants for the skid-buffered pipeline stage.
// Latency: n/a (definitions only). Backpressure: n/a.
// Optional stall statistics are enabled by the PIPE_STALL_STATS_EN macro.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    localparam int OCC_W       = 2;
    localparam int STALL_CNT_W = 16;

    function automatic logic [OCC_W-1:0] occ_of(input skid_state_t s);
        case (s)
            EMPTY:   return 2'd0;
            ONE:     return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared only by rst.
// Latency: count visible the cycle after inc. Backpressure: none.
// Used for stall statistics when PIPE_STALL_STATS_EN is defined.
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline register with 2-entry skid buffer, valid/ready handshake and flush.
// Latency: 1 cycle in_fire -> out_valid; full throughput of one beat per cycle.
// Backpressure: in_ready is a flop (low only when skid full); optional stall_cnt via PIPE_STALL_STATS_EN.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int CLEAR_ON_FLUSH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_STALL_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    skid_state_t       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_rdy_q;
    logic              out_vld_q;
    logic [OCC_W-1:0]  occ_q;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & in_rdy_q;
    assign out_fire = out_vld_q & out_ready;

    assign in_ready  = in_rdy_q;
    assign out_valid = out_vld_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Any in_fire this cycle is dropped; upstream treats it as consumed.
            state_d = EMPTY;
            if (CLEAR_ON_FLUSH != 0) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = TWO;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Handshake outputs are registered from the next state so none is combinational.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
            occ_q     <= '0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            in_rdy_q  <= (state_d != TWO);
            out_vld_q <= (state_d != EMPTY);
            occ_q     <= occ_of(state_d);
        end
    end

`ifdef PIPE_STALL_STATS_EN
    pipe_sat_counter #(
        .W (STALL_CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_vld_q & ~out_ready),
        .cnt (stall_cnt)
    );
`endif

endmodule
